uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised next-generation UART transmitter.
- Configurable data width, parity mode, stop-bit count and bit period.
- Front-end TX FIFO with a valid/ready write handshake, so producers can burst words without pacing on a ready-for-next strobe.
- Sits between on-chip data sources (pattern generators, sensor front ends) and the board TX pin.
- Sends back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per UART bit; minimum 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- nRst  in  1  reset; synchronous, active-low.
- i_data  in  DATA_BITS  word to transmit.
- i_valid  in  1  i_data valid.
- o_ready  out  1  FIFO can accept a word.
- o_Tx  out  1  serial line; idles high.
- o_busy  out  1  frame currently on the line.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  words waiting in the FIFO (excludes the word in the shifter).

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-low.
  - While nRst is low at a clk edge: o_Tx=1, o_ready=1 on the first non-reset cycle, o_busy=0, o_fifo_count=0, FSM=IDLE, FIFO pointers cleared.
  - No write is accepted during reset, regardless of i_valid.
- Write handshake
  - A word is accepted on any edge with i_valid=1 and o_ready=1.
  - o_ready = !full, purely from registered state.
  - A push while full is never accepted, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full leaves o_fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_Tx=1. If the FIFO is non-empty, pop into the shift register, load the bit counter and enter START.
  - START: o_Tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: o_Tx = current data bit, LSB first, for CLKS_PER_BIT cycles each, DATA_BITS bits. Then PARITY if PARITY!=0, else STOP.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse. Duration CLKS_PER_BIT cycles. Then STOP.
  - STOP: o_Tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the last STOP cycle: if the FIFO is non-empty, pop and go straight to START (no idle cycle); otherwise go to IDLE.
- Timing
  - Latency: a word accepted on edge k into an empty FIFO with the FSM in IDLE drives o_Tx low from edge k+2.
  - Frame length is exactly CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
  - o_busy=1 for every cycle the FSM is outside IDLE.
  - o_Tx is registered (glitch-free).
- Counters
  - Cycle counter width is $clog2(CLKS_PER_BIT).
  - The counter wraps at CLKS_PER_BIT-1 and drives state/bit advance.
  - The FIFO uses pointers of $clog2(FIFO_DEPTH)+1 bits with MSB-wrap full/empty detection.
- Reset mid-frame: the frame is abandoned, o_Tx returns high on the same edge, and FIFO contents are discarded.
- i_data and i_valid are sampled only on accepting edges. Changes on other cycles have no effect.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - FSM state encoding (IDLE..STOP).
  - a function computing frame bit count from the parameters.
- Sub-module sync_fifo: parametrised by width/depth, single clock, synchronous active-low reset. Provides push/pop/full/empty/count.
- Top level: instantiates sync_fifo and contains the serialiser FSM and counters.

Test Plan:
1. Reset: hold nRst low 3 cycles with i_valid=1, i_data=0xFF → o_Tx=1, o_busy=0, o_fifo_count=0 throughout; no frame follows; o_ready=1 after release.
2. 8N1, CLKS_PER_BIT=4, push 0x55 on edge k:
   - o_Tx=0 during cycles k+2..k+5;
   - then data 1,0,1,0,1,0,1,0, each held 4 cycles;
   - then high for 4 cycles;
   - o_busy high exactly 40 cycles.
3. PARITY=1, CLKS_PER_BIT=4, push 0x07 → parity bit 1 after the 8th data bit. Rebuilt with PARITY=2 → parity bit 0. Frame length 44 cycles in both cases.
4. FIFO_DEPTH=4, i_valid held high with words 0x01..0x06:
   - 5 words accepted (1 popped into the shifter, 4 stored), then o_ready=0;
   - o_fifo_count peaks at 4;
   - sixth word accepted one edge after the first frame's last stop cycle pops the next word;
   - all six words transmitted in order, with START of each frame immediately following STOP of the previous.
5. Push 0x3C then 0x99; drop nRst for 1 cycle during DATA bit 3 of the first frame:
   - o_Tx=1 on that edge, o_busy=0, o_fifo_count=0;
   - 0x99 never sent;
   - a subsequent push of 0xA3 transmits correctly.
6. DATA_BITS=5, STOP_BITS=2, PARITY=0, CLKS_PER_BIT=4, push 0x1F:
   - frame is start 0, five 1s, two stop 1s = 32 cycles;
   - next queued word starts on the following cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// serialiser state encoding and frame-length arithmetic.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Wide enough to index 5..8 data bits and 1..2 stop bits.
    localparam int BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Single-clock FIFO with first-word-fall-through read and extra-MSB pointers
// for full/empty detection.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage carries no reset; cleared pointers already make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a valid/ready FIFO; frames are sent back to back
// while words are queued, with a registered serial output.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_Tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   tx_q;
    logic                   busy_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   push;
    logic                   pop;
    logic                   cnt_last;
    logic                   last_stop;

    assign o_ready = !fifo_full;
    assign push    = i_valid && !fifo_full;

    assign cnt_last  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_stop = (state == ST_STOP) && cnt_last && (bit_cnt == BIT_CNT_W'(STOP_BITS - 1));
    // The last stop cycle pops directly so the next start bit follows with no idle gap.
    assign pop = !fifo_empty && ((state == ST_IDLE) || last_stop);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (push),
        .pop   (pop),
        .wdata (i_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            // Line level follows the state one cycle later, giving a glitch-free pin.
            unique case (state)
                ST_IDLE:   tx_q <= 1'b1;
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shreg[0];
                ST_PARITY: tx_q <= par_bit;
                ST_STOP:   tx_q <= 1'b1;
                default:   tx_q <= 1'b1;
            endcase

            if (pop) begin
                shreg   <= fifo_rdata;
                par_bit <= (^fifo_rdata) ^ (PARITY == PAR_ODD);
            end

            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state  <= ST_START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        shreg <= shreg >> 1;
                        if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (last_stop) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= ST_START;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four configurations share one clock and reset
// and are compared every cycle against a queue-based line model.
module tb_uart_tx_fifo_param;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DB  [N] = '{8, 8, 8, 5};
    localparam int PAR [N] = '{0, 1, 2, 0};
    localparam int SB  [N] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] din  [N];
    logic       vin  [N];
    logic       tx   [N];
    logic       busy [N];
    logic       rdy  [N];
    logic [2:0] cnt  [N];

    int total = 0;
    int bad   = 0;

    // Reference model: queued words, expected line bits per future cycle, busy cycles left.
    int fq [N][$];
    bit lq [N][$];
    int busy_left [N];
    bit acc     [N];
    bit exp_tx  [N];
    bit exp_bsy [N];
    int exp_cnt [N];
    bit exp_rdy [N];

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0]), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .nRst(nRst), .i_data(din[0]), .i_valid(vin[0]), .o_ready(rdy[0]),
        .o_Tx(tx[0]), .o_busy(busy[0]), .o_fifo_count(cnt[0]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1]), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .nRst(nRst), .i_data(din[1]), .i_valid(vin[1]), .o_ready(rdy[1]),
        .o_Tx(tx[1]), .o_busy(busy[1]), .o_fifo_count(cnt[1]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2]), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .nRst(nRst), .i_data(din[2]), .i_valid(vin[2]), .o_ready(rdy[2]),
        .o_Tx(tx[2]), .o_busy(busy[2]), .o_fifo_count(cnt[2]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(SB[3]), .FIFO_DEPTH(DEPTH)) u3 (
        .clk(clk), .nRst(nRst), .i_data(din[3][4:0]), .i_valid(vin[3]), .o_ready(rdy[3]),
        .o_Tx(tx[3]), .o_busy(busy[3]), .o_fifo_count(cnt[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void build_frame(input int i, input int w);
        bit bits[$];
        bit p;
        p = ^w;
        bits.push_back(1'b0);
        for (int k = 0; k < DB[i]; k++) bits.push_back(w[k]);
        if (PAR[i] == 1) bits.push_back(p);
        if (PAR[i] == 2) bits.push_back(!p);
        for (int k = 0; k < SB[i]; k++) bits.push_back(1'b1);
        foreach (bits[b]) for (int c = 0; c < CPB; c++) lq[i].push_back(bits[b]);
    endfunction

    // Predicts the effect of the coming edge from the inputs currently applied.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit do_pop;
            int w;
            if (!nRst) begin
                fq[i].delete();
                lq[i].delete();
                busy_left[i] = 0;
                acc[i]       = 1'b0;
                exp_tx[i]    = 1'b1;
            end else begin
                acc[i] = vin[i] && (fq[i].size() < DEPTH);
                do_pop = (busy_left[i] <= 1) && (fq[i].size() > 0);
                exp_tx[i] = (lq[i].size() > 0) ? lq[i].pop_front() : 1'b1;
                if (do_pop) begin
                    w = fq[i].pop_front();
                    build_frame(i, w);
                    busy_left[i] = CPB * (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]);
                end else if (busy_left[i] > 0) begin
                    busy_left[i]--;
                end
                if (acc[i]) fq[i].push_back(int'(din[i]) & ((1 << DB[i]) - 1));
            end
            exp_bsy[i] = (busy_left[i] > 0);
            exp_cnt[i] = fq[i].size();
            exp_rdy[i] = (fq[i].size() < DEPTH);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d_tx", i),    32'(tx[i]),   32'(exp_tx[i]));
            check($sformatf("u%0d_busy", i),  32'(busy[i]), 32'(exp_bsy[i]));
            check($sformatf("u%0d_count", i), 32'(cnt[i]),  32'(exp_cnt[i]));
            check($sformatf("u%0d_ready", i), 32'(rdy[i]),  32'(exp_rdy[i]));
        end
    endtask

    task automatic drain();
        int  guard;
        bit  idle;
        guard = 0;
        idle  = 1'b0;
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        while (!idle && guard < 2000) begin
            step();
            guard++;
            idle = 1'b1;
            for (int i = 0; i < N; i++)
                if (fq[i].size() != 0 || busy_left[i] != 0) idle = 1'b0;
        end
        check("drain_done", 32'(idle), 32'd1);
    endtask

    initial begin
        int blen [N];
        int word;
        int peak;
        int guard;

        // Reset held with a valid word pending: nothing may be accepted.
        nRst = 1'b0;
        for (int i = 0; i < N; i++) begin
            vin[i] = 1'b1;
            din[i] = 8'hFF;
        end
        repeat (3) step();
        nRst = 1'b1;
        for (int i = 0; i < N; i++) vin[i] = 1'b0;
        repeat (60) step();

        // Single word per configuration: 0x55 8N1, 0x07 8E1/8O1, 0x1F 5N2.
        din[0] = 8'h55; din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'h1F;
        for (int i = 0; i < N; i++) vin[i] = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            vin[i]  = 1'b0;
            blen[i] = 0;
        end
        for (int j = 1; j <= 60; j++) begin
            step();
            for (int i = 0; i < N; i++) if (busy[i] === 1'b1) blen[i]++;
            if (j == 1) check("lat_still_high", 32'(tx[0]), 32'd1);
            if (j == 2) check("lat_start_low", 32'(tx[0]), 32'd0);
            if (j == 6) check("d0_bit0", 32'(tx[0]), 32'd1);
            if (j == 10) check("d0_bit1", 32'(tx[0]), 32'd0);
            if (j == 39) begin
                check("even_parity_bit", 32'(tx[1]), 32'd1);
                check("odd_parity_bit", 32'(tx[2]), 32'd0);
            end
        end
        check("busy_len_8n1", blen[0], 40);
        check("busy_len_8e1", blen[1], 44);
        check("busy_len_8o1", blen[2], 44);
        check("busy_len_5n2", blen[3], 32);

        // 5N2 back-to-back: two queued words keep busy high for two whole frames.
        din[3] = 8'h1F; vin[3] = 1'b1;
        step();
        din[3] = 8'h0A;
        step();
        vin[3]  = 1'b0;
        blen[3] = 0;
        for (int j = 0; j < 80; j++) begin
            step();
            if (busy[3] === 1'b1) blen[3]++;
        end
        check("busy_len_5n2_pair", blen[3], 63);

        // Burst into a depth-4 FIFO with valid held high: words 1..6.
        word  = 1;
        peak  = 0;
        guard = 0;
        vin[0] = 1'b1;
        din[0] = 8'(word);
        while (word <= 6 && guard < 400) begin
            step();
            if (acc[0]) word++;
            din[0] = 8'(word);
            if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
            guard++;
        end
        vin[0] = 1'b0;
        check("burst_all_accepted", word, 7);
        check("burst_peak_count", peak, 4);
        drain();

        // Reset during data bit 3 of the first of two queued frames.
        din[0] = 8'h3C; vin[0] = 1'b1;
        step();
        din[0] = 8'h99;
        step();
        vin[0] = 1'b0;
        for (int j = 2; j <= 18; j++) step();
        nRst = 1'b0;
        step();
        check("midreset_tx", 32'(tx[0]), 32'd1);
        check("midreset_busy", 32'(busy[0]), 32'd0);
        check("midreset_count", 32'(cnt[0]), 32'd0);
        nRst = 1'b1;
        repeat (60) step();
        din[0] = 8'hA3; vin[0] = 1'b1;
        step();
        drain();

        // Random traffic on every configuration, including data changes while stalled.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                vin[i] = ($urandom_range(0, 3) == 0);
                din[i] = 8'($urandom);
            end
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
